// File: rtl/microseq_control_unit.sv
`timescale 1ns/1ps
// Microsequenced fetch/decode/execute controller for the shared-bus datapath.
// Optional ALU watchdog: define ALU_TIMEOUT_EN (adds ALU_TIMEOUT, alu_timeout).

module microseq_control_unit #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 10,
  parameter int REG_SEL_W = 3,
  parameter int MEM_WAIT  = 1
`ifdef ALU_TIMEOUT_EN
  ,
  parameter int ALU_TIMEOUT = 64
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_W-1:0]    instruction,
  input  logic [3:0]           flags,
  input  logic                 alu_done,
  output logic                 pc_inc,
  output logic                 jump_en,
  output logic [DATA_W-1:0]    jump_addr,
  output logic                 flag_write_en,
  output logic [REG_SEL_W-1:0] reg_s_in,
  output logic [REG_SEL_W-1:0] reg_s_out,
  output logic                 reg_write_en,
  output logic                 reg_out_en,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [1:0]           mem_addr_src,
  output logic [4:0]           alu_op,
  output logic                 start,
  output logic                 alu_src_b_imm,
  output logic                 alu_out_en,
  output logic                 ir_load,
  output logic                 halted,
  output logic                 illegal_op
`ifdef ALU_TIMEOUT_EN
  ,
  output logic                 alu_timeout
`endif
);

  localparam logic [5:0] OP_LOAD  = 6'b000001;
  localparam logic [5:0] OP_STORE = 6'b000010;
  localparam logic [5:0] OP_ADD   = 6'b000011;
  localparam logic [5:0] OP_SUB   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_DIV   = 6'b000110;
  localparam logic [5:0] OP_MOD   = 6'b000111;
  localparam logic [5:0] OP_MOV   = 6'b010000;
  localparam logic [5:0] OP_CMP   = 6'b010001;
  localparam logic [5:0] OP_JMP   = 6'b100000;
  localparam logic [5:0] OP_BRN   = 6'b100001;
  localparam logic [5:0] OP_BRC   = 6'b100010;
  localparam logic [5:0] OP_BRZ   = 6'b100011;
  localparam logic [5:0] OP_BRV   = 6'b100100;
  localparam logic [5:0] OP_BRNZ  = 6'b100101;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  localparam int WC_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

  typedef enum logic [3:0] {
    S_F_WAIT,
    S_F_LOAD,
    S_DECODE,
    S_O_RD,
    S_O_USE,
    S_STORE,
    S_EXEC,
    S_LAUNCH,
    S_ALU_WAIT,
    S_MOV,
    S_CMP,
    S_BRANCH,
    S_HALT
  } state_t;

  state_t state, state_nxt;

  logic [WC_W-1:0]      wait_cnt, wait_nxt;
  logic                 wait_last;
  logic                 set_illegal;
  logic [5:0]           opcode;
  logic [REG_SEL_W-1:0] target_reg;
  logic [4:0]           mdo_op;
  logic                 br_take;
  logic                 f_z, f_n, f_c, f_v;

  assign opcode     = instruction[DATA_W-1:DATA_W-6];
  assign target_reg = REG_SEL_W'(instruction[DATA_W-7:DATA_W-8])
                    + REG_SEL_W'(1);
  assign wait_last  = (wait_cnt == WC_W'(MEM_WAIT - 1));
  assign {f_z, f_n, f_c, f_v} = flags;

`ifdef ALU_TIMEOUT_EN
  localparam int TC_W = $clog2(ALU_TIMEOUT + 1);

  logic [TC_W-1:0] tmo_cnt;
  logic            tmo_last;
  logic            tmo_set;

  assign tmo_last = (tmo_cnt == TC_W'(ALU_TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt     <= '0;
      alu_timeout <= 1'b0;
    end else begin
      if (state == S_LAUNCH)
        tmo_cnt <= '0;
      else if (state == S_ALU_WAIT)
        tmo_cnt <= tmo_cnt + TC_W'(1);
      if (tmo_set)
        alu_timeout <= 1'b1;
    end
  end
`endif

  always_comb begin
    unique case (opcode)
      OP_MUL:  mdo_op = 5'd7;
      OP_DIV:  mdo_op = 5'd2;
      default: mdo_op = 5'd5;
    endcase
  end

  always_comb begin
    br_take = 1'b0;
    unique case (1'b1)
      (opcode == OP_JMP):  br_take = 1'b1;
      (opcode == OP_BRN):  br_take = f_n;
      (opcode == OP_BRC):  br_take = f_c;
      (opcode == OP_BRZ):  br_take = f_z;
      (opcode == OP_BRV):  br_take = f_v;
      (opcode == OP_BRNZ): br_take = ~f_z;
      default:             br_take = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_F_WAIT;
      wait_cnt   <= '0;
      illegal_op <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (set_illegal)
        illegal_op <= 1'b1;
    end
  end

  always_comb begin
    state_nxt     = state;
    wait_nxt      = '0;
    set_illegal   = 1'b0;
    pc_inc        = 1'b0;
    jump_en       = 1'b0;
    jump_addr     = '0;
    flag_write_en = 1'b0;
    reg_s_in      = '0;
    reg_s_out     = '0;
    reg_write_en  = 1'b0;
    reg_out_en    = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_addr_src  = 2'd0;
    alu_op        = 5'd0;
    start         = 1'b0;
    alu_src_b_imm = 1'b0;
    alu_out_en    = 1'b0;
    ir_load       = 1'b0;
    halted        = 1'b0;
`ifdef ALU_TIMEOUT_EN
    tmo_set       = 1'b0;
`endif
    unique case (state)
      S_F_WAIT: begin
        mem_read = 1'b1;
        if (wait_last) state_nxt = S_F_LOAD;
        else           wait_nxt  = wait_cnt + WC_W'(1);
      end
      S_F_LOAD: begin
        mem_read  = 1'b1;
        ir_load   = 1'b1;
        pc_inc    = 1'b1;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        unique case (opcode)
          OP_LOAD, OP_ADD, OP_SUB,
          OP_MUL, OP_DIV, OP_MOD: state_nxt = S_O_RD;
          OP_STORE:               state_nxt = S_STORE;
          OP_MOV:                 state_nxt = S_MOV;
          OP_CMP:                 state_nxt = S_CMP;
          OP_JMP, OP_BRN, OP_BRC,
          OP_BRZ, OP_BRV, OP_BRNZ: state_nxt = S_BRANCH;
          OP_HLT:                 state_nxt = S_HALT;
          default: begin
            set_illegal = 1'b1;
            state_nxt   = S_F_WAIT;
          end
        endcase
      end
      S_O_RD: begin
        mem_read     = 1'b1;
        mem_addr_src = 2'd1;
        if (!wait_last)
          wait_nxt = wait_cnt + WC_W'(1);
        else if (opcode == OP_LOAD)
          state_nxt = S_O_USE;
        else if (opcode == OP_ADD || opcode == OP_SUB)
          state_nxt = S_EXEC;
        else
          state_nxt = S_LAUNCH;
      end
      S_O_USE: begin
        mem_read     = 1'b1;
        mem_addr_src = 2'd1;
        reg_write_en = 1'b1;
        reg_s_in     = target_reg;
        state_nxt    = S_F_WAIT;
      end
      S_STORE: begin
        mem_addr_src = 2'd1;
        reg_s_out    = target_reg;
        reg_out_en   = 1'b1;
        mem_write    = 1'b1;
        state_nxt    = S_F_WAIT;
      end
      S_EXEC: begin
        alu_op        = (opcode == OP_SUB) ? 5'd14 : 5'd10;
        alu_out_en    = 1'b1;
        reg_write_en  = 1'b1;
        reg_s_in      = target_reg;
        flag_write_en = 1'b1;
        state_nxt     = S_F_WAIT;
      end
      S_LAUNCH: begin
        alu_op    = mdo_op;
        start     = 1'b1;
        state_nxt = S_ALU_WAIT;
      end
      S_ALU_WAIT: begin
        alu_op = mdo_op;
        if (alu_done) begin
          alu_out_en    = 1'b1;
          reg_write_en  = 1'b1;
          reg_s_in      = target_reg;
          flag_write_en = 1'b1;
          state_nxt     = S_F_WAIT;
        end
`ifdef ALU_TIMEOUT_EN
        else if (tmo_last) begin
          tmo_set   = 1'b1;
          state_nxt = S_F_WAIT;
        end
`endif
      end
      S_MOV: begin
        alu_src_b_imm = 1'b1;
        alu_op        = 5'd6;
        alu_out_en    = 1'b1;
        reg_write_en  = 1'b1;
        reg_s_in      = target_reg;
        state_nxt     = S_F_WAIT;
      end
      S_CMP: begin
        alu_src_b_imm = 1'b1;
        alu_op        = 5'd17;
        flag_write_en = 1'b1;
        state_nxt     = S_F_WAIT;
      end
      S_BRANCH: begin
        jump_en   = br_take;
        jump_addr = DATA_W'(instruction[ADDR_W-1:0]);
        state_nxt = S_F_WAIT;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_nxt = S_F_WAIT;
    endcase
  end

endmodule

// File: tb/tb_microseq_control_unit.sv
`timescale 1ns/1ps
// Scoreboarded bench: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares them against each DUT.

module tb_microseq_control_unit;

  typedef struct packed {
    logic        pc_inc;
    logic        jump_en;
    logic [15:0] jump_addr;
    logic        flag_write_en;
    logic [2:0]  reg_s_in;
    logic [2:0]  reg_s_out;
    logic        reg_write_en;
    logic        reg_out_en;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_addr_src;
    logic [4:0]  alu_op;
    logic        start;
    logic        alu_src_b_imm;
    logic        alu_out_en;
    logic        ir_load;
    logic        halted;
    logic        illegal_op;
    logic        tmo;
  } outs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, rst3, done1, done3;
  logic [15:0] instr1, instr3;
  logic [3:0]  flags1, flags3;

  logic        pci1, jen1, fwe1, rwe1, roe1, mrd1, mwr1;
  logic        st1, imm1, aoe1, irl1, hlt1, ill1, tmo1;
  logic [15:0] ja1;
  logic [2:0]  rsi1, rso1;
  logic [1:0]  src1;
  logic [4:0]  aop1;
  logic        pci3, jen3, fwe3, rwe3, roe3, mrd3, mwr3;
  logic        st3, imm3, aoe3, irl3, hlt3, ill3, tmo3;
  logic [15:0] ja3;
  logic [2:0]  rsi3, rso3;
  logic [1:0]  src3;
  logic [4:0]  aop3;

`ifndef ALU_TIMEOUT_EN
  assign tmo1 = 1'b0;
  assign tmo3 = 1'b0;
`endif

  microseq_control_unit #(
    .MEM_WAIT(1)
`ifdef ALU_TIMEOUT_EN
    , .ALU_TIMEOUT(8)
`endif
  ) u1 (
    .clk(clk), .rst(rst1), .instruction(instr1), .flags(flags1),
    .alu_done(done1), .pc_inc(pci1), .jump_en(jen1), .jump_addr(ja1),
    .flag_write_en(fwe1), .reg_s_in(rsi1), .reg_s_out(rso1),
    .reg_write_en(rwe1), .reg_out_en(roe1), .mem_read(mrd1),
    .mem_write(mwr1), .mem_addr_src(src1), .alu_op(aop1), .start(st1),
    .alu_src_b_imm(imm1), .alu_out_en(aoe1), .ir_load(irl1),
    .halted(hlt1), .illegal_op(ill1)
`ifdef ALU_TIMEOUT_EN
    , .alu_timeout(tmo1)
`endif
  );

  microseq_control_unit #(
    .MEM_WAIT(3)
`ifdef ALU_TIMEOUT_EN
    , .ALU_TIMEOUT(8)
`endif
  ) u3 (
    .clk(clk), .rst(rst3), .instruction(instr3), .flags(flags3),
    .alu_done(done3), .pc_inc(pci3), .jump_en(jen3), .jump_addr(ja3),
    .flag_write_en(fwe3), .reg_s_in(rsi3), .reg_s_out(rso3),
    .reg_write_en(rwe3), .reg_out_en(roe3), .mem_read(mrd3),
    .mem_write(mwr3), .mem_addr_src(src3), .alu_op(aop3), .start(st3),
    .alu_src_b_imm(imm3), .alu_out_en(aoe3), .ir_load(irl3),
    .halted(hlt3), .illegal_op(ill3)
`ifdef ALU_TIMEOUT_EN
    , .alu_timeout(tmo3)
`endif
  );

  outs_t act1, act3;
  assign act1 = {pci1, jen1, ja1, fwe1, rsi1, rso1, rwe1, roe1, mrd1,
                 mwr1, src1, aop1, st1, imm1, aoe1, irl1, hlt1, ill1, tmo1};
  assign act3 = {pci3, jen3, ja3, fwe3, rsi3, rso3, rwe3, roe3, mrd3,
                 mwr3, src3, aop3, st3, imm3, aoe3, irl3, hlt3, ill3, tmo3};

  outs_t q1[$], q3[$];
  string t1[$], t3[$];
  int    nvec = 0;
  int    nbad = 0;
  logic  exp_ill = 1'b0;
  logic  exp_tmo = 1'b0;

  logic [15:0] br_i [9] = '{16'h8D55, 16'h8D55, 16'h9420, 16'h9420,
                            16'h8401, 16'h8802, 16'h9004, 16'h9004,
                            16'h83FF};
  logic [3:0]  br_f [9] = '{4'b1000, 4'b0000, 4'b0000, 4'b1000,
                            4'b0100, 4'b0010, 4'b0001, 4'b1110,
                            4'b0000};
  logic        br_t [9] = '{1'b1, 1'b0, 1'b1, 1'b0,
                            1'b1, 1'b1, 1'b1, 1'b0,
                            1'b1};
  logic [15:0] br_a [9] = '{16'h0155, 16'h0155, 16'h0020, 16'h0020,
                            16'h0001, 16'h0002, 16'h0004, 16'h0004,
                            16'h03FF};

  task automatic chk(input outs_t a, input outs_t e, input string tag);
    nvec++;
    if (a !== e) begin
      nbad++;
      $display("FAIL %s: got %h want %h", tag, a, e);
    end
  endtask

  always @(negedge clk) begin
    if (q1.size() != 0) chk(act1, q1.pop_front(), t1.pop_front());
    if (q3.size() != 0) chk(act3, q3.pop_front(), t3.pop_front());
  end

  function automatic outs_t base();
    outs_t o;
    o = '0;
    o.illegal_op = exp_ill;
    o.tmo = exp_tmo;
    return o;
  endfunction

  task automatic push(input int d, input outs_t e, input string tag);
    if (d == 3) begin
      q3.push_back(e);
      t3.push_back({"u3/", tag});
    end else begin
      q1.push_back(e);
      t1.push_back({"u1/", tag});
    end
  endtask

  task automatic wait_empty(input int d);
    int n = 0;
    while (((d == 3) ? q3.size() : q1.size()) != 0 && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (((d == 3) ? q3.size() : q1.size()) != 0) begin
      nvec++;
      nbad++;
      $display("FAIL drain u%0d: %0d left want 0", d,
               (d == 3) ? q3.size() : q1.size());
      q1.delete(); t1.delete(); q3.delete(); t3.delete();
    end
  endtask

  task automatic issue(input int d, input logic [15:0] ins,
                       input logic [3:0] fl);
    wait_empty(d);
    @(posedge clk);
    #1;
    if (d == 3) begin
      rst3 = 1'b0; instr3 = ins; flags3 = fl; done3 = 1'b0;
    end else begin
      rst1 = 1'b0; instr1 = ins; flags1 = fl; done1 = 1'b0;
    end
  endtask

  task automatic fetch(input int d, input string tag);
    outs_t e;
    int mw = (d == 3) ? 3 : 1;
    for (int i = 0; i < mw; i++) begin
      e = base(); e.mem_read = 1'b1;
      push(d, e, {tag, "/fwait"});
    end
    e = base(); e.mem_read = 1'b1; e.ir_load = 1'b1; e.pc_inc = 1'b1;
    push(d, e, {tag, "/fload"});
    push(d, base(), {tag, "/decode"});
  endtask

  task automatic ord(input int d, input string tag);
    outs_t e;
    int mw = (d == 3) ? 3 : 1;
    for (int i = 0; i < mw; i++) begin
      e = base(); e.mem_read = 1'b1; e.mem_addr_src = 2'd1;
      push(d, e, {tag, "/ord"});
    end
  endtask

  task automatic one(input int d, input logic [15:0] ins,
                     input logic [3:0] fl, input outs_t e,
                     input string tag);
    issue(d, ins, fl);
    fetch(d, tag);
    push(d, e, tag);
  endtask

  task automatic rst_snap(input int d, input string tag);
    outs_t e;
    e = '0; e.mem_read = 1'b1;
    push(d, e, tag);
  endtask

  task automatic add_seq(input int d, input logic [15:0] ins,
                         input logic [2:0] tgt, input string tag);
    outs_t e;
    issue(d, ins, 4'h0);
    fetch(d, tag);
    ord(d, tag);
    e = base(); e.alu_op = 5'd10; e.alu_out_en = 1'b1;
    e.reg_write_en = 1'b1; e.flag_write_en = 1'b1; e.reg_s_in = tgt;
    push(d, e, {tag, "/exec"});
  endtask

  task automatic load_seq(input int d, input logic [15:0] ins,
                          input logic [2:0] tgt);
    outs_t e;
    issue(d, ins, 4'h0);
    fetch(d, "load");
    ord(d, "load");
    e = base(); e.mem_read = 1'b1; e.mem_addr_src = 2'd1;
    e.reg_write_en = 1'b1; e.reg_s_in = tgt;
    push(d, e, "load/use");
  endtask

  function automatic outs_t mov_exp(input logic [2:0] tgt);
    outs_t e;
    e = base(); e.alu_src_b_imm = 1'b1; e.alu_op = 5'd6;
    e.alu_out_en = 1'b1; e.reg_write_en = 1'b1; e.reg_s_in = tgt;
    return e;
  endfunction

  initial begin
    outs_t e;
    rst1 = 1'b1; rst3 = 1'b1; done1 = 1'b0; done3 = 1'b0;
    instr1 = '0; instr3 = '0; flags1 = '0; flags3 = '0;

    rst_snap(1, "reset0");
    rst_snap(1, "reset1");

    one(1, 16'h42AA, 4'h0, mov_exp(3'd3), "mov");

    e = base(); e.alu_src_b_imm = 1'b1; e.alu_op = 5'd17;
    e.flag_write_en = 1'b1;
    one(1, 16'h44FF, 4'h0, e, "cmp");

    e = base(); e.mem_addr_src = 2'd1; e.reg_s_out = 3'd4;
    e.reg_out_en = 1'b1; e.mem_write = 1'b1;
    one(1, 16'h0BC0, 4'h0, e, "store");

    load_seq(1, 16'h0555, 3'd2);
    add_seq(1, 16'h0D55, 3'd2, "add");

    issue(1, 16'h1012, 4'h0);
    fetch(1, "sub");
    ord(1, "sub");
    e = base(); e.alu_op = 5'd14; e.alu_out_en = 1'b1;
    e.reg_write_en = 1'b1; e.flag_write_en = 1'b1; e.reg_s_in = 3'd1;
    push(1, e, "sub/exec");

    for (int k = 0; k < 9; k++) begin
      e = base(); e.jump_en = br_t[k]; e.jump_addr = br_a[k];
      one(1, br_i[k], br_f[k], e, $sformatf("branch%0d", k));
    end

    issue(1, 16'h1633, 4'h0);
    fetch(1, "mul");
    ord(1, "mul");
    e = base(); e.alu_op = 5'd7; e.start = 1'b1;
    push(1, e, "mul/launch");
    e.start = 1'b0;
    for (int i = 0; i < 6; i++) push(1, e, "mul/wait");
    e.alu_out_en = 1'b1; e.reg_write_en = 1'b1;
    e.flag_write_en = 1'b1; e.reg_s_in = 3'd3;
    push(1, e, "mul/done");
    repeat (4) @(posedge clk);
    #1 done1 = 1'b1;
    @(posedge clk);
    #1 done1 = 1'b0;
    repeat (6) @(posedge clk);
    #1 done1 = 1'b1;

    issue(1, 16'h1900, 4'h0);
    fetch(1, "div");
    ord(1, "div");
    e = base(); e.alu_op = 5'd2; e.start = 1'b1;
    push(1, e, "div/launch");
    e.start = 1'b0; e.alu_out_en = 1'b1; e.reg_write_en = 1'b1;
    e.flag_write_en = 1'b1; e.reg_s_in = 3'd2;
    push(1, e, "div/done");
    repeat (5) @(posedge clk);
    #1 done1 = 1'b1;

    issue(1, 16'h1F00, 4'h0);
    fetch(1, "mod");
    ord(1, "mod");
    e = base(); e.alu_op = 5'd5; e.start = 1'b1;
    push(1, e, "mod/launch");
    e.start = 1'b0;
    push(1, e, "mod/wait");
    e.alu_out_en = 1'b1; e.reg_write_en = 1'b1;
    e.flag_write_en = 1'b1; e.reg_s_in = 3'd4;
    push(1, e, "mod/done");
    repeat (6) @(posedge clk);
    #1 done1 = 1'b1;

    issue(1, 16'h0D55, 4'h0);
    fetch(1, "addrst");
    rst_snap(1, "addrst/rsthi");
    rst_snap(1, "addrst/rsthi");
    fetch(1, "addrst/re");
    ord(1, "addrst/re");
    e = base(); e.alu_op = 5'd10; e.alu_out_en = 1'b1;
    e.reg_write_en = 1'b1; e.flag_write_en = 1'b1; e.reg_s_in = 3'd2;
    push(1, e, "addrst/exec");
    repeat (3) @(posedge clk);
    #1 rst1 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst1 = 1'b0;

    issue(1, 16'h3C00, 4'h0);
    fetch(1, "illegal");
    exp_ill = 1'b1;

    add_seq(1, 16'h0D55, 3'd2, "add_sticky");

    issue(1, 16'hFC00, 4'h0);
    fetch(1, "hlt");
    e = base(); e.halted = 1'b1;
    for (int i = 0; i < 20; i++) push(1, e, "hlt/halt");

    wait_empty(1);
    @(posedge clk);
    #1 rst1 = 1'b1;
    exp_ill = 1'b0;
    rst_snap(1, "hltrst");
    rst_snap(1, "hltrst");

    one(1, 16'h42AA, 4'h0, mov_exp(3'd3), "mov_after_rst");

`ifdef ALU_TIMEOUT_EN
    issue(1, 16'h1900, 4'h0);
    fetch(1, "divto");
    ord(1, "divto");
    e = base(); e.alu_op = 5'd2; e.start = 1'b1;
    push(1, e, "divto/launch");
    e.start = 1'b0;
    for (int i = 0; i < 8; i++) push(1, e, "divto/wait");
    exp_tmo = 1'b1;
    one(1, 16'h42AA, 4'h0, mov_exp(3'd3), "mov_after_to");
    exp_tmo = 1'b0;
`endif

    add_seq(3, 16'h0D55, 3'd2, "add_mw3");
    load_seq(3, 16'h0555, 3'd2);
    one(3, 16'h42AA, 4'h0, mov_exp(3'd3), "mov_mw3");

    wait_empty(1);
    wait_empty(3);
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
